// File: rtl/gate_test_seq_if.sv
// gate_test_seq_if: start/done handshake, gate drive and result signals of gate_test_seq
interface gate_test_seq_if;
  logic       start;
  logic [1:0] fn;
  logic       q;
  logic       a;
  logic       b;
  logic       busy;
  logic       done;
  logic       pass;
  logic [2:0] err_count;
  logic [1:0] fail_vec;
  logic       fail_seen;
  modport master (
    output start, fn, q,
    input  a, b, busy, done, pass, err_count, fail_vec, fail_seen
  );
  modport slave (
    input  start, fn, q,
    output a, b, busy, done, pass, err_count, fail_vec, fail_seen
  );
endinterface

// File: rtl/gate_test_seq.sv
// gate_test_seq: sweeps a 2-input gate through 00,01,10,11 and checks q; GATE_TEST_STOP_ON_ERR_EN ends the sweep at the first mismatch
module gate_test_seq #(
  parameter int SETTLE_CYCLES = 4
) (
  input logic            clk,
  input logic            rst,
  gate_test_seq_if.slave bus
);
  localparam int CW = $clog2(SETTLE_CYCLES + 1);
  localparam logic [CW-1:0] RELOAD = CW'(SETTLE_CYCLES - 1);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t        state, state_n;
  logic [1:0]    fn_r, fn_n, vec, vec_n, fail_vec_r, fail_vec_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0]    err, err_n;
  logic          busy_r, busy_n, done_r, done_n, pass_r, pass_n, seen_r, seen_n;
  logic          expected, mismatch, last;
  // {a,b} is the vector index itself, so it returns to 00 whenever the index is cleared
  assign bus.a         = vec[1];
  assign bus.b         = vec[0];
  assign bus.busy      = busy_r;
  assign bus.done      = done_r;
  assign bus.pass      = pass_r;
  assign bus.err_count = err;
  assign bus.fail_vec  = fail_vec_r;
  assign bus.fail_seen = seen_r;
  always_comb begin
    expected = fn_r == 2'b00 ? ~(vec[1] | vec[0]) :
               fn_r == 2'b01 ? ~(vec[1] & vec[0]) :
               fn_r == 2'b10 ?  (vec[1] & vec[0]) :
                                (vec[1] | vec[0]);
    mismatch = bus.q != expected;
`ifdef GATE_TEST_STOP_ON_ERR_EN
    last = (vec == 2'd3) || mismatch;
`else
    last = vec == 2'd3;
`endif
  end
  always_comb begin
    state_n    = state;
    fn_n       = fn_r;
    vec_n      = vec;
    cnt_n      = cnt;
    err_n      = err;
    busy_n     = busy_r;
    done_n     = 1'b0;
    pass_n     = pass_r;
    seen_n     = seen_r;
    fail_vec_n = fail_vec_r;
    case (state)
      IDLE: if (bus.start) begin
        fn_n       = bus.fn;
        err_n      = 3'd0;
        seen_n     = 1'b0;
        fail_vec_n = 2'd0;
        pass_n     = 1'b0;
        vec_n      = 2'd0;
        cnt_n      = RELOAD;
        busy_n     = 1'b1;
        state_n    = RUN;
      end
      RUN: if (cnt != '0) begin
        cnt_n = cnt - CW'(1);
      end else begin
        if (mismatch) begin
          err_n = err + 3'd1;
          if (!seen_r) begin
            seen_n     = 1'b1;
            fail_vec_n = vec;
          end
        end
        if (last) begin
          state_n = DONE;
          busy_n  = 1'b0;
          done_n  = 1'b1;
          vec_n   = 2'd0;
          pass_n  = err_n == 3'd0;
        end else begin
          vec_n = vec + 2'd1;
          cnt_n = RELOAD;
        end
      end
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      fn_r       <= 2'd0;
      vec        <= 2'd0;
      cnt        <= '0;
      err        <= 3'd0;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      pass_r     <= 1'b0;
      seen_r     <= 1'b0;
      fail_vec_r <= 2'd0;
    end else begin
      state      <= state_n;
      fn_r       <= fn_n;
      vec        <= vec_n;
      cnt        <= cnt_n;
      err        <= err_n;
      busy_r     <= busy_n;
      done_r     <= done_n;
      pass_r     <= pass_n;
      seen_r     <= seen_n;
      fail_vec_r <= fail_vec_n;
    end
  end
endmodule
